pipe_stage_skid_reg: RTL and testbench
======================================

# pipe_stage_skid_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and saturating per-stage stall/flush statistics. It is the generic successor to the fixed-width IF/ID stage register and sits between any two stages of the 5-stage MIPS pipeline, e.g. IF/ID, where `in_data` = {instr, PCPlusFour}. A registered `in_ready` lets hazard back-pressure propagate upstream without a combinational ready chain.

## Interface
- `WIDTH`, 64, payload width in bits.
- `CNT_W`, 16, width of each statistics counter.
- `RESET_VALUE`, 0, value driven on `out_data` after reset or flush.

- `clk`  in  1  clock; all state updates on the falling edge, same as the other pipeline stage registers.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous flush; discards all held entries.
- `in_valid`  in  1  upstream has data.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` is valid; registered.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  payload to next stage.
- `occupancy`  out  2  entries held, 0..2.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.
- `flush_cnt`  out  CNT_W  flushes that discarded at least one entry, saturating.

## Operation
- Storage: main entry (drives `out_data`) plus one skid entry.
- Fire: input fire = `in_valid && in_ready`; output fire = `out_valid && out_ready`.
- States: EMPTY (0 entries), BUSY (main valid), FULL (main + skid valid).
- `in_ready` = (state != FULL). `out_valid` = (state != EMPTY). `occupancy` is 0/1/2 for EMPTY/BUSY/FULL.
- EMPTY:
  - input fire: main <= `in_data`, go to BUSY.
- BUSY:
  - input and output fire: main <= `in_data`, stay in BUSY.
  - input fire only: skid <= `in_data`, go to FULL.
  - output fire only: go to EMPTY.
- FULL:
  - output fire: main <= skid, go to BUSY. No input fire is possible while FULL.
- Flush:
  - Priority is `rst` > `flush` > normal operation.
  - On flush: state goes to EMPTY and `out_data` <= `RESET_VALUE`. Input data presented in the flush cycle is dropped even if `in_valid && in_ready`. A concurrent output fire is still treated as consumed.
  - `flush_cnt` increments if occupancy was nonzero before the flush.
- Counters: increment by 1 per qualifying cycle and hold at all-ones. A flush cycle never increments `stall_cnt`.
- `out_data` holds its last value in EMPTY, except after reset or flush, where it is `RESET_VALUE`.
- Payload ordering is strictly FIFO. Nothing is ever duplicated or dropped except on flush or reset.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `in_ready` 1, `occupancy` 0, `out_data` `RESET_VALUE`, skid `RESET_VALUE`, both counters 0.
- Reset asserted mid-operation discards all entries on that edge.
- Latency: 1 clock edge from input fire into EMPTY until `out_valid` = 1.
- Throughput: 1 transfer per cycle in steady state (BUSY with both sides firing).
- Back-pressure: `out_ready` may drop with no notice. The skid entry absorbs the one in-flight word, and `in_ready` falls on the following edge.
- `in_ready` and `out_valid` come straight from flops. There is no combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Release: `out_ready` rising while FULL gives BUSY and `in_ready` = 1 after one edge.

## Structure
- Package `pipe_pkg`:
  - `stage_state_t` enum: EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b10.
  - `PIPE_CNT_W` default constant.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst`, `inc`, `count`), instantiated twice for `stall_cnt` and `flush_cnt`.
- Top level: state register, main and skid payload registers, next-state logic.

## Test plan
- Reset then stream A1..A8 with `out_ready` = 1: `out_data` = A1..A8 on consecutive cycles, `occupancy` = 1 throughout, `stall_cnt` = 0.
- Hold `out_ready` = 0 for 3 cycles while streaming:
  - one word enters the skid, `occupancy` reaches 2, `in_ready` drops on the next edge.
  - `stall_cnt` = 3.
  - After release, order is preserved (A1, A2, A3…).
- Pulse `flush` while FULL with `in_valid` = 1 (payload 0xDEAD): next edge gives `occupancy` 0, `out_valid` 0, `out_data` = `RESET_VALUE`, 0xDEAD never appears, `flush_cnt` = 1.
- Pulse `flush` while EMPTY: `flush_cnt` stays 0 and `in_ready` stays 1.
- With `CNT_W` = 4, hold a stall for 20 cycles: `stall_cnt` saturates at 15.
- Assert `rst` mid-stream with `rst` and `flush` together: all reset values, counters 0, and the first post-reset input appears with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared types and defaults for the skid-buffered pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } stage_state_t;

  localparam int PIPE_CNT_W = 16;

  function automatic logic [1:0] occ_of(input stage_state_t st);
    logic [1:0] occ;
    case (st)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating up-counter: holds at all-ones, cleared by synchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  // Count on the falling edge alongside the stage registers.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_count <= {W{1'b0}};
    end else if (inc && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one skid entry,
// synchronous flush and saturating stall/flush statistics.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 64,
  parameter int               CNT_W       = PIPE_CNT_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_state_t     r_state;
  stage_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_occ;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_stall_inc;
  logic             w_flush_inc;

  // Fires use the registered handshake flags, so ready never depends on out_ready combinationally.
  assign w_in_fire   = in_valid && r_in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_stall_inc = r_out_valid && !out_ready && !flush;
  assign w_flush_inc = flush && (r_state != EMPTY);

  // Next-state and payload selection; flush overrides the handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = RESET_VALUE;
      w_skid_nxt  = RESET_VALUE;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = BUSY;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt  = in_data;
            w_state_nxt = FULL;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end else begin
            w_state_nxt = BUSY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = BUSY;
          end else begin
            w_state_nxt = FULL;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = RESET_VALUE;
          w_skid_nxt  = RESET_VALUE;
        end
      endcase
    end
  end

  // Stage registers; handshake flags are decoded from the next state so they leave flops directly.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_main      <= RESET_VALUE;
      r_skid      <= RESET_VALUE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      r_occ       <= occ_of(w_state_nxt);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed plus random checks of pipe_stage_skid_reg against a queue-based reference model.
module tb_pipe_stage_skid_reg;

  localparam int          W    = 64;
  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [63:0] RV   = 64'hC0DE_0000_0000_5A5A;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] mq[$];
  logic [63:0] m_od;
  int          m_stall, m_flush;
  logic [63:0] seq_d;

  pipe_stage_skid_reg #(.WIDTH(W), .CNT_W(CW), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, let the DUT take its edge, compare everything.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [63:0] d, input logic ordy);
    bit mvalid, mready;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    mvalid = (mq.size() > 0);
    mready = (mq.size() < 2);
    if (r) begin
      mq.delete(); m_od = RV; m_stall = 0; m_flush = 0;
    end else if (f) begin
      if (mvalid && m_flush < CMAX) m_flush++;
      mq.delete(); m_od = RV;
    end else begin
      if (mvalid && !ordy && m_stall < CMAX) m_stall++;
      if (mvalid && ordy) void'(mq.pop_front());
      if (iv && mready) mq.push_back(d);
      if (mq.size() > 0) m_od = mq[0];
    end
    @(negedge clk); #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, mq.size() < 2});
    chk("occupancy", {62'd0, occupancy}, 64'(mq.size()));
    chk("out_data",  out_data, m_od);
    chk("stall_cnt", {60'd0, stall_cnt}, 64'(m_stall));
    chk("flush_cnt", {60'd0, flush_cnt}, 64'(m_flush));
  endtask

  // Streams sequential payloads, advancing the payload only once the model says it was taken.
  task automatic feed(input logic ordy, input int n);
    for (int i = 0; i < n; i++) begin
      bit take;
      take = (mq.size() < 2);
      step(1'b0, 1'b0, 1'b1, seq_d, ordy);
      if (take) seq_d = seq_d + 64'd1;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
    m_od = RV; m_stall = 0; m_flush = 0;

    // Reset values.
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("rst_out_data", out_data, RV);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming A1..A8 at full rate.
    seq_d = 64'h0000_0000_0000_00A1;
    feed(1'b1, 8);
    chk("stream_last", out_data, 64'h0000_0000_0000_00A8);
    chk("stream_occ", {62'd0, occupancy}, 64'd1);
    chk("stream_stall", {60'd0, stall_cnt}, 64'd0);

    // Three-cycle back-pressure while streaming, then release.
    feed(1'b0, 1);
    chk("bp_occ2", {62'd0, occupancy}, 64'd2);
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    feed(1'b0, 2);
    chk("bp_stall3", {60'd0, stall_cnt}, 64'd3);
    feed(1'b1, 6);

    // Flush while FULL with 0xDEAD presented.
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    feed(1'b0, 3);
    step(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_DEAD, 1'b0);
    chk("flush_occ", {62'd0, occupancy}, 64'd0);
    chk("flush_data", out_data, RV);
    chk("flush_cnt1", {60'd0, flush_cnt}, 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);

    // Flush while EMPTY does not count.
    step(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
    chk("flush_empty_cnt", {60'd0, flush_cnt}, 64'd1);
    chk("flush_empty_rdy", {63'd0, in_ready}, 64'd1);

    // Long stall saturates the 4-bit counter.
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    feed(1'b0, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("stall_sat", {60'd0, stall_cnt}, 64'd15);
    feed(1'b1, 4);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), {$urandom, $urandom},
           ($urandom_range(0, 2) != 0));
    end

    // Reset together with flush mid-stream, then single-edge latency.
    feed(1'b0, 2);
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_BEEF, 1'b1);
    chk("rstfl_occ", {62'd0, occupancy}, 64'd0);
    chk("rstfl_flush", {60'd0, flush_cnt}, 64'd0);
    step(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0B01, 1'b0);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_data", out_data, 64'h0000_0000_0000_0B01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
